// File: rtl/fba_accumulator_pkg.sv
// Shared widths and FSM state encoding for the fixed-bounding accumulator.
package fba_accumulator_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/fba_accumulator_adder.sv
// Fixed-bounding adder: upper byte adds exactly, lower byte saturates at 0xFF
// instead of carrying, so the upper byte never sees a carry-in.
module fba_adder
  import fba_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);
  logic [8:0] lo_sum;
  logic [8:0] hi_sum;

  assign lo_sum = {1'b0, a[7:0]} + {1'b0, b[7:0]};
  assign hi_sum = {1'b0, a[15:8]} + {1'b0, b[15:8]};

  // A lower-byte carry is absorbed by clamping rather than propagated upward.
  assign sum  = {hi_sum[7:0], (lo_sum[8] ? 8'hFF : lo_sum[7:0])};
  assign cout = hi_sum[8];
endmodule

// File: rtl/fba_accumulator.sv
// Windowed accumulator: sums a burst of operands (ended by last or MAX_LEN beats)
// and holds the result until consumed; result visible one cycle after the final beat.
module fba_accumulator
  import fba_accumulator_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int APPROX  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              accept;
  logic              win_end;

  generate
    if (APPROX != 0) begin : g_approx
      fba_adder u_adder (
        .a    (acc),
        .b    (in_data),
        .sum  (add_sum),
        .cout (add_cout)
      );
    end else begin : g_exact
      logic [DATA_W:0] full_sum;
      assign full_sum = {1'b0, acc} + {1'b0, in_data};
      assign add_sum  = full_sum[DATA_W-1:0];
      assign add_cout = full_sum[DATA_W];
    end
  endgenerate

  assign accept  = in_valid & in_ready;
  // Count-limit and last on the same beat still close just one window.
  assign win_end = in_last | (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= add_sum;
            ovf <= ovf | add_cout;
            cnt <= cnt + 1'b1;
            if (win_end) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum   = out_valid ? acc : '0;
  assign out_ovf   = out_valid & ovf;
  assign out_count = out_valid ? cnt : '0;
endmodule

// File: tb/tb_fba_accumulator.sv
// Directed bench for fba_accumulator: approximate and exact instances share stimulus.
module tb_fba_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        ex_in_ready, ex_out_valid, ex_out_ovf;
  logic [15:0] ex_out_sum;
  logic [7:0]  ex_out_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fba_accumulator #(.MAX_LEN(64), .APPROX(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_count(out_count)
  );

  fba_accumulator #(.MAX_LEN(64), .APPROX(0)) dut_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ex_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(ex_out_valid),
    .out_ready(out_ready), .out_sum(ex_out_sum), .out_ovf(ex_out_ovf),
    .out_count(ex_out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat at a falling edge; it is taken on the following rising edge.
  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pop_valid_low", {31'b0, out_valid}, 32'd0);
    check("pop_ready_high", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sum", {16'b0, out_sum}, 32'd0);
    check("rst_out_count", {24'b0, out_count}, 32'd0);
    rst = 1'b0;

    // 0x00FF + 0x0001: lower byte saturates in the approximate adder.
    send(16'h00FF, 1'b0);
    check("mid_window_valid", {31'b0, out_valid}, 32'd0);
    check("mid_window_sum_zero", {16'b0, out_sum}, 32'd0);
    send(16'h0001, 1'b1);
    check("fba_valid", {31'b0, out_valid}, 32'd1);
    check("fba_sum", {16'b0, out_sum}, 32'h00FF);
    check("fba_ovf", {31'b0, out_ovf}, 32'd0);
    check("fba_count", {24'b0, out_count}, 32'd2);
    check("exact_sum", {16'b0, ex_out_sum}, 32'h0100);
    check("exact_count", {24'b0, ex_out_count}, 32'd2);

    // Backpressure: result held, extra input ignored.
    in_valid = 1'b1; in_data = 16'hAAAA; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_ready", {31'b0, in_ready}, 32'd0);
      check("hold_sum", {16'b0, out_sum}, 32'h00FF);
      check("hold_count", {24'b0, out_count}, 32'd2);
    end
    in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
    pop();
    check("after_pop_sum", {16'b0, out_sum}, 32'd0);

    // 0x8000 + 0x8000 wraps to zero with carry-out.
    send(16'h8000, 1'b0);
    send(16'h8000, 1'b1);
    check("wrap_sum", {16'b0, out_sum}, 32'h0000);
    check("wrap_ovf", {31'b0, out_ovf}, 32'd1);
    check("wrap_count", {24'b0, out_count}, 32'd2);
    check("wrap_exact_ovf", {31'b0, ex_out_ovf}, 32'd1);
    pop();
    check("wrap_cleared_ovf", {31'b0, out_ovf}, 32'd0);

    // 64 beats without last close the window at MAX_LEN.
    for (int i = 0; i < 63; i++) send(16'h0100, 1'b0);
    check("len63_not_valid", {31'b0, out_valid}, 32'd0);
    send(16'h0100, 1'b0);
    check("len64_valid", {31'b0, out_valid}, 32'd1);
    check("len64_sum", {16'b0, out_sum}, 32'h4000);
    check("len64_count", {24'b0, out_count}, 32'd64);
    check("len64_ovf", {31'b0, out_ovf}, 32'd0);
    check("len64_exact_sum", {16'b0, ex_out_sum}, 32'h4000);
    pop();

    // last on the MAX_LEN-th beat ends exactly one window.
    for (int i = 0; i < 63; i++) send(16'h0001, 1'b0);
    send(16'h0001, 1'b1);
    check("last_at_max_valid", {31'b0, out_valid}, 32'd1);
    check("last_at_max_sum", {16'b0, out_sum}, 32'h0040);
    check("last_at_max_count", {24'b0, out_count}, 32'd64);
    pop();
    @(negedge clk);
    check("no_second_window", {31'b0, out_valid}, 32'd0);

    // Single beat: result visible the very next cycle.
    send(16'h1234, 1'b1);
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_sum", {16'b0, out_sum}, 32'h1234);
    check("single_count", {24'b0, out_count}, 32'd1);

    // Reset in HOLD takes effect without a clock edge.
    rst = 1'b1;
    #1;
    check("rst_hold_valid", {31'b0, out_valid}, 32'd0);
    check("rst_hold_ready", {31'b0, in_ready}, 32'd1);
    check("rst_hold_sum", {16'b0, out_sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Partial window discarded by reset.
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send(16'h0005, 1'b1);
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_sum", {16'b0, out_sum}, 32'h0005);
    check("post_rst_count", {24'b0, out_count}, 32'd1);
    pop();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fba_accumulator.md
FBA_ACCUMULATOR -- requirements
Module: fba_accumulator

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, maximum operands per window (range 1..255).
REQ-002 SHALL have parameter APPROX, default 1; 1 selects the fixed-bounding adder datapath, 0 selects an exact 16-bit adder.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand present.
REQ-007 SHALL have port in_ready, output, 1 bit: operand accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data, input, 16 bits: unsigned operand.
REQ-009 SHALL have port in_last, input, 1 bit: final operand of the window.
REQ-010 SHALL have port out_valid, output, 1 bit: result held.
REQ-011 SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port out_sum, output, 16 bits: accumulated window sum.
REQ-013 SHALL have port out_ovf, output, 1 bit: sticky carry-out seen during the window.
REQ-014 SHALL have port out_count, output, 8 bits: number of operands in the window.

Function
REQ-015 SHALL implement two states: ACC and HOLD.
REQ-016 In ACC, SHALL drive in_ready=1 and out_valid=0.
REQ-017 In HOLD, SHALL drive in_ready=0 and out_valid=1.
REQ-018 On each accepted beat, SHALL update acc <= add(acc, in_data), where add is the selected 16-bit adder with carry-in 0; acc starts each window at 0.
REQ-019 On each accepted beat, SHALL update ovf <= ovf OR cout, and cnt <= cnt+1.
REQ-020 A window SHALL end on the accepted beat with in_last=1, or on the accepted beat that brings cnt to MAX_LEN, whichever comes first.
REQ-021 On window end, SHALL transition ACC->HOLD in the same edge that registers the final acc, ovf and cnt.
REQ-022 out_valid SHALL rise the cycle after the final beat is accepted (latency 1).
REQ-023 In HOLD, out_sum, out_ovf and out_count SHALL stay stable while out_ready=0.
REQ-024 On a HOLD handshake, SHALL transition HOLD->ACC and clear acc, ovf and cnt to 0; in_ready SHALL be 1 on the following cycle (one bubble cycle, no overlap).
REQ-025 in_valid asserted in HOLD SHALL be ignored; no beat SHALL be consumed.
REQ-026 in_last on a beat with cnt=MAX_LEN-1 SHALL end exactly one window, not two.
REQ-027 Wrap-around of acc modulo 2^16 SHALL be permitted; it is reported only via out_ovf.
REQ-028 out_sum, out_ovf and out_count SHALL read 0 whenever out_valid=0.

Reset
REQ-029 rst asserted SHALL immediately force state=ACC, acc=0, ovf=0, cnt=0, out_valid=0 and in_ready=1, including mid-window or in HOLD; the partial window SHALL be discarded.
REQ-030 The first edge after rst deasserts SHALL be able to accept a beat.

Structure
REQ-031 A shared package SHALL hold DATA_W=16, CNT_W=8 and the state enumeration (ACC, HOLD).
REQ-032 The block SHALL instantiate one fba_adder sub-module (16-bit fixed-bounding adder with upper byte exact and lower byte bounded) when APPROX=1, and an exact 17-bit adder when APPROX=0.

Verification
REQ-033 With APPROX=1, stream 0x00FF then 0x0001 with last -> out_sum=0x00FF, out_ovf=0, out_count=2; with APPROX=0 -> out_sum=0x0100.
REQ-034 Stream 0x8000 then 0x8000 with last -> out_sum=0x0000, out_ovf=1, out_count=2.
REQ-035 Stream 64 beats of 0x0100 with no last -> window closes at beat 64: out_sum=0x4000, out_count=64, out_ovf=0.
REQ-036 After REQ-033, hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, in_ready stays 0, outputs stable, no beat consumed.
REQ-037 Accept 3 beats, then pulse rst -> out_valid=0 and in_ready=1 immediately; next window 0x0005 with last -> out_sum=0x0005, out_count=1.
REQ-038 Single beat 0x1234 with last -> out_valid on the next cycle, out_sum=0x1234, out_count=1.
